// File: rtl/rsa_core_arbiter.sv
// rsa_core_arbiter: shares a single Rsa256Core between N_REQ requesters.
// A round-robin arbiter picks one requester while idle, latches its operands,
// pulses core_start, waits for core_finished and hands the result back to the
// owning requester only. One operation is in flight at a time.
// Optional build macro RSA_ARB_FIXED_PRIO_EN: lowest asserted index always
// wins and the round-robin pointer is held at zero.
module rsa_core_arbiter #(
    parameter int N_REQ = 2,
    parameter int W     = 256
) (
    input  logic               avm_clk,
    input  logic               avm_rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_d,
    input  logic [N_REQ*W-1:0] req_n,
    output logic [N_REQ-1:0]   resp_valid,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [W-1:0]       resp_data,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               core_start,
    output logic [W-1:0]       core_a,
    output logic [W-1:0]       core_d,
    output logic [W-1:0]       core_n,
    input  logic [W-1:0]       core_result,
    input  logic               core_finished
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot_f(input logic [2:0] idx);
        logic [N_REQ-1:0] v;
        v = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == idx) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [2:0]       rr_ptr_r;
    logic [2:0]       base_s;
    logic [2:0]       grant_s;
    logic             any_s;
    logic             accept_s;
    logic             resp_hs_s;
    logic [2:0]       grant_id_r;
    logic [W-1:0]     sel_a_s;
    logic [W-1:0]     sel_d_s;
    logic [W-1:0]     sel_n_s;
    logic [W-1:0]     core_a_r;
    logic [W-1:0]     core_d_r;
    logic [W-1:0]     core_n_r;
    logic [W-1:0]     result_r;
    logic             busy_r;
    logic             core_start_r;
    logic [N_REQ-1:0] resp_valid_r;

`ifdef RSA_ARB_FIXED_PRIO_EN
    assign base_s = 3'd0;
`else
    assign base_s = rr_ptr_r;
`endif

    // Wrap-around search: first pass from base upward, second pass below base.
    always_comb begin
        any_s   = 1'b0;
        grant_s = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_s && req_valid[i] && (i >= int'(base_s))) begin
                any_s   = 1'b1;
                grant_s = 3'(i);
            end else begin
                any_s   = any_s;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_s && req_valid[i] && (i < int'(base_s))) begin
                any_s   = 1'b1;
                grant_s = 3'(i);
            end else begin
                any_s   = any_s;
            end
        end
    end

    assign accept_s  = (state_r == ST_IDLE) && any_s;
    assign resp_hs_s = (state_r == ST_RESP) && (|(resp_ready & onehot_f(grant_id_r)));

    // Accept strobe is combinational so the requester sees it in the accept cycle.
    always_comb begin
        if (accept_s) begin
            req_ready = onehot_f(grant_s);
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Operand mux selecting the winning requester's slice.
    always_comb begin
        sel_a_s = {W{1'b0}};
        sel_d_s = {W{1'b0}};
        sel_n_s = {W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == grant_s) begin
                sel_a_s = req_a[i*W +: W];
                sel_d_s = req_d[i*W +: W];
                sel_n_s = req_n[i*W +: W];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Next-state logic; core_finished only matters while BUSY.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: state_s = ST_BUSY;
            ST_BUSY: begin
                if (core_finished) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (resp_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and state-decoded outputs, pre-decoded from the next state.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            core_start_r <= 1'b0;
            resp_valid_r <= {N_REQ{1'b0}};
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != ST_IDLE);
            core_start_r <= (state_s == ST_START);
            resp_valid_r <= (state_s == ST_RESP) ? onehot_f(grant_id_r) : {N_REQ{1'b0}};
        end
    end

    // Owner index and operand latch, updated only on an accept.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            grant_id_r <= 3'd0;
            core_a_r   <= {W{1'b0}};
            core_d_r   <= {W{1'b0}};
            core_n_r   <= {W{1'b0}};
        end else if (accept_s) begin
            grant_id_r <= grant_s;
            core_a_r   <= sel_a_s;
            core_d_r   <= sel_d_s;
            core_n_r   <= sel_n_s;
        end
    end

    // Result capture on the finishing cycle of BUSY.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            result_r <= {W{1'b0}};
        end else if ((state_r == ST_BUSY) && core_finished) begin
            result_r <= core_result;
        end
    end

    // Round-robin pointer advances past the owner on the response handshake.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            rr_ptr_r <= 3'd0;
        end else if (resp_hs_s) begin
`ifdef RSA_ARB_FIXED_PRIO_EN
            rr_ptr_r <= 3'd0;
`else
            rr_ptr_r <= (grant_id_r == 3'(N_REQ - 1)) ? 3'd0 : (grant_id_r + 3'd1);
`endif
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_data  = result_r;
    assign grant_id   = grant_id_r;
    assign busy       = busy_r;
    assign core_start = core_start_r;
    assign core_a     = core_a_r;
    assign core_d     = core_d_r;
    assign core_n     = core_n_r;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Testbench for rsa_core_arbiter: behavioural core (finish 8 cycles after
// start, result a^d mod n), table-driven single operations, directed
// multi-cycle corner cases and a randomized run against a queue-free
// arbitration reference model.
module tb_rsa_core_arbiter;

    localparam int N = 2;
    localparam int W = 256;

    logic           clk = 1'b0;
    logic           avm_rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_d;
    logic [N*W-1:0] req_n;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   resp_data;
    logic [2:0]     grant_id;
    logic           busy;
    logic           core_start;
    logic [W-1:0]   core_a;
    logic [W-1:0]   core_d;
    logic [W-1:0]   core_n;
    logic [W-1:0]   core_result;
    logic           core_finished;

    logic           model_fin = 1'b0;
    logic [W-1:0]   model_res = {W{1'b0}};
    int             model_cnt = 0;
    logic           spur_fin;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rsa_core_arbiter #(.N_REQ(N), .W(W)) dut (
        .avm_clk      (clk),
        .avm_rst      (avm_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_d        (req_d),
        .req_n        (req_n),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .core_start   (core_start),
        .core_a       (core_a),
        .core_d       (core_d),
        .core_n       (core_n),
        .core_result  (core_result),
        .core_finished(core_finished)
    );

    function automatic longint unsigned modexp(input longint unsigned a,
                                               input longint unsigned d,
                                               input longint unsigned n);
        longint unsigned r, b, e;
        if (n == 0) return 0;
        r = 1 % n;
        b = a % n;
        e = d;
        while (e > 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign core_finished = model_fin | spur_fin;
    assign core_result   = spur_fin ? {W{1'b1}} : model_res;

    // Behavioural core: finished pulses in the 8th cycle after the start cycle.
    always @(posedge clk) begin
        if (core_start) begin
            model_cnt <= 7;
            model_res <= W'(modexp(64'(core_a), 64'(core_d), 64'(core_n)));
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
        end
        model_fin <= (model_cnt == 1) && !core_start;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chkd(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_req(input int idx, input longint unsigned a, input longint unsigned d,
                           input longint unsigned n);
        req_a[idx*W +: W] = W'(a);
        req_d[idx*W +: W] = W'(d);
        req_n[idx*W +: W] = W'(n);
        req_valid[idx]    = 1'b1;
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (req_ready == '0 && waited < 50) begin
            step();
            waited++;
        end
        chk("ready_timeout", 64'(req_ready != '0), 64'd1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (resp_valid == '0 && lat < 50) begin
            step();
            lat++;
        end
        chk("resp_timeout", 64'(resp_valid != '0), 64'd1);
    endtask

    // Full single operation with timing checks; response accepted immediately.
    task automatic do_op(input int idx, input longint unsigned a, input longint unsigned d,
                         input longint unsigned n, input longint unsigned res);
        int w;
        int lat;
        set_req(idx, a, d, n);
        #1;
        wait_ready(w);
        chk("ready_onehot", 64'(req_ready), 64'(oh(idx)));
        step();
        req_valid[idx] = 1'b0;
        #1;
        chk("start_after_accept", 64'(core_start), 64'd1);
        chk("ready_pulse_once", 64'(req_ready), 64'd0);
        chk("grant_id", 64'(grant_id), 64'(idx));
        chk("busy_in_start", 64'(busy), 64'd1);
        chkd("core_a_latched", core_a, W'(a));
        chkd("core_n_latched", core_n, W'(n));
        step();
        chk("start_one_cycle", 64'(core_start), 64'd0);
        wait_resp(lat);
        chk("resp_latency", 64'(lat + 1), 64'd9);
        chk("resp_onehot", 64'(resp_valid), 64'(oh(idx)));
        chkd("resp_data", resp_data, W'(res));
        resp_ready[idx] = 1'b1;
        step();
        resp_ready[idx] = 1'b0;
        chk("resp_dropped", 64'(resp_valid), 64'd0);
        chk("idle_after_hs", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int              idx;
        longint unsigned a;
        longint unsigned d;
        longint unsigned n;
        longint unsigned res;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int w;
        int lat;
        int exp_g;
        longint unsigned e0, e1;
        longint unsigned op_a [N];
        longint unsigned op_d [N];
        longint unsigned op_n [N];
        logic [N-1:0] drop;
        logic [W-1:0] exp_res;
        int rr_m, owner, ops, cyc;
        bit inflight;

        tbl[0] = '{0, 2, 10, 1000, 24};
        tbl[1] = '{1, 3, 5, 7, 5};
        tbl[2] = '{0, 5, 3, 13, 8};
        tbl[3] = '{1, 7, 2, 10, 9};
        tbl[4] = '{0, 10, 0, 7, 1};
        tbl[5] = '{1, 4, 13, 497, 445};

        avm_rst = 1'b1; req_valid = '0; resp_ready = '0; spur_fin = 1'b0;
        req_a = '0; req_d = '0; req_n = '0;
        repeat (3) step();
        avm_rst = 1'b0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chkd("rst_core_a", core_a, {W{1'b0}});
        chkd("rst_resp_data", resp_data, {W{1'b0}});

        // Table of isolated operations
        for (int k = 0; k < 6; k++) begin
            do_op(tbl[k].idx, tbl[k].a, tbl[k].d, tbl[k].n, tbl[k].res);
            step();
        end

        // Contention: both requesters hold valid for 4 operations
        e0 = modexp(3, 7, 11);
        e1 = modexp(6, 5, 23);
        set_req(0, 3, 7, 11);
        set_req(1, 6, 5, 23);
        #1;
        for (int op = 0; op < 4; op++) begin
`ifdef RSA_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = op % 2;
`endif
            wait_ready(w);
            if (op > 0) chk("turnaround", 64'(w), 64'd0);
            chk("cont_grant", 64'(req_ready), 64'(oh(exp_g)));
            step();
            wait_resp(lat);
            chk("cont_resp_onehot", 64'(resp_valid), 64'(oh(exp_g)));
            chkd("cont_resp_data", resp_data, W'((exp_g == 0) ? e0 : e1));
            resp_ready = oh(exp_g);
            step();
            resp_ready = '0;
            if (op == 3) req_valid = '0;
            #1;
        end
        step();

        // Backpressure: 20 stalled cycles with a competing request and foreign ready
        set_req(0, 9, 4, 100);
        #1;
        wait_ready(w);
        step();
        req_valid[0] = 1'b0;
        wait_resp(lat);
        set_req(1, 2, 9, 1000);
        resp_ready = 2'b10;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chkd("bp_resp_data", resp_data, W'(61));
            chk("bp_no_grant", 64'(req_ready), 64'd0);
        end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        #1;
        chk("bp_next_grant", 64'(req_ready), 64'(oh(1)));
        step();
        req_valid[1] = 1'b0;
        wait_resp(lat);
        chkd("bp_second_data", resp_data, W'(512));
        resp_ready = 2'b10;
        step();
        resp_ready = '0;
        step();

        // Reset in BUSY, 3 cycles after core_start
        set_req(1, 3, 4, 50);
        #1;
        wait_ready(w);
        step();
        req_valid[1] = 1'b0;
        chk("rb_start", 64'(core_start), 64'd1);
        chk("rb_grant", 64'(grant_id), 64'd1);
        repeat (3) step();
        avm_rst = 1'b1;
        step();
        avm_rst = 1'b0;
        chk("rb_busy", 64'(busy), 64'd0);
        chk("rb_resp_valid", 64'(resp_valid), 64'd0);
        chk("rb_grant_id", 64'(grant_id), 64'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rb_late_finish_ignored", 64'({busy, resp_valid}), 64'd0);
        end
        do_op(0, 2, 10, 1000, 24);
        step();

        // Spurious finish in IDLE and in RESP
        spur_fin = 1'b1;
        step();
        spur_fin = 1'b0;
        chk("sp_idle_busy", 64'(busy), 64'd0);
        chk("sp_idle_resp", 64'(resp_valid), 64'd0);
        step();
        chk("sp_idle_busy2", 64'(busy), 64'd0);
        set_req(0, 5, 3, 13);
        #1;
        wait_ready(w);
        step();
        req_valid[0] = 1'b0;
        wait_resp(lat);
        spur_fin = 1'b1;
        step();
        spur_fin = 1'b0;
        chk("sp_resp_valid", 64'(resp_valid), 64'd1);
        chkd("sp_resp_data", resp_data, W'(8));
        step();
        chkd("sp_resp_data2", resp_data, W'(8));
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        chk("sp_done", 64'(busy), 64'd0);

        // Randomized run against the arbitration reference model (fresh reset)
        avm_rst = 1'b1;
        step();
        avm_rst = 1'b0;
        rr_m = 0; owner = 0; ops = 0; cyc = 0; inflight = 1'b0; drop = '0; exp_res = '0;
        while (ops < 30 && cyc < 4000) begin
            step();
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (drop[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    op_a[i] = $urandom_range(1, 60);
                    op_d[i] = $urandom_range(0, 25);
                    op_n[i] = $urandom_range(2, 999);
                    set_req(i, op_a[i], op_d[i], op_n[i]);
                end
            end
            drop = '0;
            resp_ready = N'($urandom);
            #1;
            if (req_ready != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid[(rr_m + k) % N]) w = (rr_m + k) % N;
                end
                chk("rand_accept_when_idle", 64'(inflight), 64'd0);
                chk("rand_grant", 64'(req_ready), 64'(oh(w)));
                inflight = 1'b1;
                owner    = w;
                exp_res  = W'(modexp(op_a[w], op_d[w], op_n[w]));
                drop[w]  = 1'b1;
            end
            if (resp_valid != '0) begin
                chk("rand_resp_owner", 64'(resp_valid), 64'(oh(owner)));
                chkd("rand_resp_data", resp_data, exp_res);
                if (resp_ready[owner]) begin
                    inflight = 1'b0;
                    ops++;
`ifdef RSA_ARB_FIXED_PRIO_EN
                    rr_m = 0;
`else
                    rr_m = (owner + 1) % N;
`endif
                end
            end
        end
        chk("rand_ops_done", 64'(ops), 64'd30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
